rr_mux: RTL and testbench

- Parametrised successor to the team's 2:1 combinational mux.
- Selects one of NUM_CH valid/ready input streams of WIDTH bits each.
- Selection uses fixed-priority or round-robin arbitration.
- The winner is registered into a single output stage with backpressure.
- Sits between multiple producers and one shared consumer, and tags each output beat with its source channel.

---
 rtl/rr_mux_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 49 ++++
 rtl/rr_mux.sv | 61 ++++++
 tb/tb_rr_mux.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/rr_mux_pkg.sv
// Shared types and helpers for the rr_mux arbitrated stream multiplexer.
package rr_mux_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  // A single channel still needs a one-bit index.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Fixed-priority / round-robin arbiter. Owns the last-grant pointer.
module rr_arbiter
  import rr_mux_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int ARB_MODE = 1,
  localparam int CH_W    = clog2_min1(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  output logic [NUM_CH-1:0] gnt,
  output logic [CH_W-1:0]   gnt_idx
);

  localparam logic [CH_W-1:0] LAST_RST = CH_W'(NUM_CH - 1);

  logic [CH_W-1:0] last_grant;
  logic [CH_W-1:0] c;
  logic            found;

  // In fixed-priority mode the pointer never leaves its reset value.
  always_ff @(posedge clk) begin
    if (reset || (ARB_MODE != int'(ARB_RR)))
      last_grant <= LAST_RST;
    else if (advance && found)
      last_grant <= gnt_idx;
  end

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    c       = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ARB_MODE == int'(ARB_RR))
        c = CH_W'((int'(last_grant) + 1 + i) % NUM_CH);
      else
        c = CH_W'(i);
      if (!found && req[c]) begin
        found   = 1'b1;
        gnt[c]  = 1'b1;
        gnt_idx = c;
      end
    end
  end

endmodule

// File: rtl/rr_mux.sv
// N-way valid/ready stream mux with a single registered output stage
// tagged with the source channel.
module rr_mux
  import rr_mux_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int WIDTH    = 8,
  parameter int ARB_MODE = 1,
  localparam int CH_W    = clog2_min1(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            in_valid_i,
  input  logic [NUM_CH-1:0][WIDTH-1:0] in_data_i,
  output logic [NUM_CH-1:0]            in_ready_o,
  output logic                         out_valid_o,
  output logic [WIDTH-1:0]             out_data_o,
  output logic [CH_W-1:0]              out_ch_o,
  input  logic                         out_ready_i
);

  logic              load;
  logic              active;
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] gnt;
  logic [CH_W-1:0]   gnt_idx;

  assign load   = !out_valid_o || out_ready_i;
  // Reset gates the grant so no producer sees ready while reset is high.
  assign active = load && !reset;
  assign req    = active ? in_valid_i : '0;

  rr_arbiter #(
    .NUM_CH  (NUM_CH),
    .ARB_MODE(ARB_MODE)
  ) u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .advance(active),
    .gnt    (gnt),
    .gnt_idx(gnt_idx)
  );

  assign in_ready_o = gnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_ch_o    <= '0;
    end else if (load) begin
      out_valid_o <= |gnt;
      if (|gnt) begin
        out_data_o <= in_data_i[gnt_idx];
        out_ch_o   <= gnt_idx;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux.sv
// Directed bench for rr_mux: one round-robin and one fixed-priority instance,
// expected beats queued at acceptance and popped when they appear.
module tb_rr_mux;

  typedef struct packed {
    logic [1:0] ch;
    logic [7:0] data;
  } beat_t;

  logic            clk = 1'b0;
  logic            r_reset, f_reset;
  logic [3:0]      r_valid, f_valid;
  logic [3:0][7:0] r_data, f_data;
  logic [3:0]      r_ready, f_ready;
  logic            r_ovalid, f_ovalid;
  logic [7:0]      r_odata, f_odata;
  logic [1:0]      r_och, f_och;
  logic            r_oready, f_oready;

  int checks = 0;
  int errors = 0;
  beat_t sb[$];

  always #5 clk = ~clk;

  rr_mux #(.NUM_CH(4), .WIDTH(8), .ARB_MODE(1)) u_rr (
    .clk(clk), .reset(r_reset), .in_valid_i(r_valid), .in_data_i(r_data),
    .in_ready_o(r_ready), .out_valid_o(r_ovalid), .out_data_o(r_odata),
    .out_ch_o(r_och), .out_ready_i(r_oready)
  );

  rr_mux #(.NUM_CH(4), .WIDTH(8), .ARB_MODE(0)) u_fp (
    .clk(clk), .reset(f_reset), .in_valid_i(f_valid), .in_data_i(f_data),
    .in_ready_o(f_ready), .out_valid_o(f_ovalid), .out_data_o(f_odata),
    .out_ch_o(f_och), .out_ready_i(f_oready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic push(input logic [1:0] ch, input logic [7:0] d);
    sb.push_back('{ch: ch, data: d});
  endtask

  task automatic expect_beat(input string tag, input logic v, input logic [1:0] ch,
                             input logic [7:0] d);
    beat_t e;
    chk({tag, "_sb"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk({tag, "_valid"}, 32'(v), 32'd1);
    chk({tag, "_ch"}, 32'(ch), 32'(e.ch));
    chk({tag, "_data"}, 32'(d), 32'(e.data));
  endtask

  initial begin
    r_reset = 1'b1; f_reset = 1'b1;
    r_valid = 4'b1111; f_valid = 4'b0000;
    r_data = '0; f_data = '0;
    r_oready = 1'b1; f_oready = 1'b1;

    // Reset with all channels requesting
    step(); step();
    chk("rst_ready", 32'(r_ready), 32'h0);
    chk("rst_valid", 32'(r_ovalid), 32'h0);
    chk("rst_data", 32'(r_odata), 32'h0);
    chk("rst_ch", 32'(r_och), 32'h0);
    r_reset = 1'b0; r_valid = 4'b0000;
    step();
    chk("post_rst_valid", 32'(r_ovalid), 32'h0);
    chk("post_rst_ch", 32'(r_och), 32'h0);

    // Single channel
    r_valid = 4'b0100; r_data[2] = 8'hA5;
    settle();
    chk("single_ready", 32'(r_ready), 32'b0100);
    push(2'd2, 8'hA5);
    step();
    r_valid = 4'b0000;
    expect_beat("single", r_ovalid, r_och, r_odata);

    // Fresh pointer, then round-robin over all four plus two more beats
    r_reset = 1'b1;
    step();
    r_reset = 1'b0;
    for (int k = 0; k < 4; k++) r_data[k] = 8'h10 + 8'(k);
    r_valid = 4'b1111;
    for (int k = 0; k < 10; k++) begin
      settle();
      chk($sformatf("rr_ready%0d", k), 32'(r_ready), 32'(1 << (k % 4)));
      push(2'(k % 4), 8'h10 + 8'(k % 4));
      step();
      expect_beat($sformatf("rr%0d", k), r_ovalid, r_och, r_odata);
    end

    // Backpressure holding the ch1 beat
    r_oready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk($sformatf("stall_ready%0d", k), 32'(r_ready), 32'h0);
      step();
      chk($sformatf("stall_valid%0d", k), 32'(r_ovalid), 32'h1);
      chk($sformatf("stall_data%0d", k), 32'(r_odata), 32'h11);
      chk($sformatf("stall_ch%0d", k), 32'(r_och), 32'h1);
    end
    r_oready = 1'b1;
    settle();
    chk("resume_ready", 32'(r_ready), 32'b0100);
    push(2'd2, 8'h12);
    step();
    expect_beat("resume", r_ovalid, r_och, r_odata);
    r_valid = 4'b0000;
    step();
    chk("drain_empty", 32'(r_ovalid), 32'h0);

    // Reset while stalled on a ch2 beat
    r_valid = 4'b0100;
    settle();
    chk("ms_ready", 32'(r_ready), 32'b0100);
    push(2'd2, 8'h12);
    step();
    expect_beat("ms_load", r_ovalid, r_och, r_odata);
    r_oready = 1'b0; r_valid = 4'b1111;
    step();
    chk("ms_hold_ch", 32'(r_och), 32'h2);
    r_reset = 1'b1;
    settle();
    chk("ms_rst_ready", 32'(r_ready), 32'h0);
    step();
    chk("ms_rst_valid", 32'(r_ovalid), 32'h0);
    r_reset = 1'b0; r_oready = 1'b1;
    settle();
    chk("ms_first_ready", 32'(r_ready), 32'b0001);
    push(2'd0, 8'h10);
    step();
    expect_beat("ms_first", r_ovalid, r_och, r_odata);
    r_valid = 4'b0000;
    step();

    // Fixed priority: ch1 beats ch3 until ch1 drops
    f_reset = 1'b0;
    f_data[1] = 8'h21; f_data[3] = 8'h33;
    f_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk($sformatf("fp_ready%0d", k), 32'(f_ready), 32'b0010);
      push(2'd1, 8'h21);
      step();
      expect_beat($sformatf("fp%0d", k), f_ovalid, f_och, f_odata);
    end
    f_valid = 4'b1000;
    settle();
    chk("fp_ch3_ready", 32'(f_ready), 32'b1000);
    push(2'd3, 8'h33);
    step();
    expect_beat("fp_ch3", f_ovalid, f_och, f_odata);
    f_valid = 4'b0000;
    step();
    chk("fp_empty", 32'(f_ovalid), 32'h0);

    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
